rtc_clock: RTL
==============

Name: rtc_clock

Overview:
- BCD time-of-day counter (hours:minutes:seconds) for the PULPissimo RTC.
- Sits directly upstream of the calendar date counter and drives its new_day_i input.
- Divides the RTC reference clock to a 1 Hz tick, keeps time in packed BCD, and provides a software-loadable alarm with a one-shot or repeat mode.

Parameters:
- PRESCALE, 32768, number of clk_i cycles per second; must be at least 2.
- CNT_W, 15, width of the prescaler counter; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk_i  in  1  RTC reference clock; nominally 32.768 kHz.
- rstn_i  in  1  asynchronous, active-low reset.
- clock_en_i  in  1  counting enable; when low, the prescaler and time are frozen.
- time_update_i  in  1  one-cycle pulse that loads time_i into the time registers.
- time_i  in  32  packed BCD time: [21:16] hour, [14:8] minute, [6:0] second; all other bits ignored.
- time_o  out  32  packed current time: {10'b0, hour[5:0], 1'b0, min[6:0], 1'b0, sec[6:0]}.
- new_day_o  out  1  one-cycle pulse on midnight rollover; connects to the date block's new_day_i.
- alarm_update_i  in  1  loads alarm_i and alarm_mode_i, and arms the alarm.
- alarm_i  in  32  alarm time in the same packing as time_i.
- alarm_mode_i  in  1  0 = one-shot (disarm after firing), 1 = repeat daily.
- alarm_clear_i  in  1  disarms the alarm.
- alarm_armed_o  out  1  alarm armed status.
- alarm_o  out  1  one-cycle alarm event pulse.
- tick_o  out  1  one-cycle 1 Hz tick, for debug and timestamping.

Behaviour:
- Reset values:
  - time = 00:00:00, so time_o = 32'h0.
  - prescaler = 0.
  - alarm register = 0, mode = 0.
  - alarm_armed_o = 0, alarm_o = 0, new_day_o = 0, tick_o = 0.
- Reset is asynchronous. Asserting it mid-count clears all state immediately, with no pending pulses after release.
- Prescaler:
  - Increments each cycle while clock_en_i = 1.
  - At value PRESCALE-1 it wraps to 0 and asserts an internal tick in that cycle.
  - tick_o is that tick, registered (1-cycle latency).
  - With clock_en_i = 0, the prescaler holds and no tick is generated.
- Time increment, applied on the clock edge where the tick is active:
  - sec[3:0] increments if != 9; otherwise it goes to 0 and sec[6:4] increments.
  - Seconds wrap from 0x59 to 0x00 and carry into minutes; minutes follow the same rule.
  - Hours: the units digit wraps at 9 into the tens digit; 0x23 wraps to 0x00.
  - time_o reflects the new value one cycle after the tick cycle. Latency from prescaler wrap to time_o change is 1 cycle.
- new_day_o:
  - Registered pulse, asserted in the same cycle time_o first shows 00:00:00 after 23:59:59.
  - Exactly 1 cycle wide.
  - Not asserted when software loads 00:00:00.
- time_update_i:
  - On the next edge, loads sec = time_i[6:0], min = time_i[14:8], hour = time_i[21:16], and clears the prescaler to 0.
  - Has priority over a coincident tick: that tick is dropped, and no new_day_o or alarm_o results from it.
  - Loads are taken regardless of clock_en_i.
  - No BCD range checking. Software must write valid BCD; counting from an invalid value follows the digit rules above and is not specified further.
- Alarm:
  - alarm_update_i stores the alarm fields and mode, and sets armed = 1.
  - alarm_clear_i sets armed = 0. If alarm_clear_i and alarm_update_i coincide, clear wins and the alarm value is still stored.
  - On a tick, if armed and the next time value equals the stored alarm (hour, min, sec fields only), alarm_o pulses for 1 cycle, aligned with the time_o update.
  - After firing in one-shot mode, armed clears in the same cycle alarm_o rises. In repeat mode, armed stays 1.
  - Software loads via time_update_i never fire the alarm, even if the loaded time equals the alarm.
  - alarm_o and new_day_o may assert in the same cycle (alarm at 00:00:00).
- All outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
- Reset, PRESCALE=4, clock_en_i=1 -> tick_o pulses every 4 cycles; time_o shows 0x00000001 after the first tick, then 0x00000002.
- Load 0x00235958, then 2 ticks -> 0x00235959, then 0x00000000 with new_day_o = 1 for exactly that one cycle.
- Load 0x00095959, then 1 tick -> 0x00100000; load 0x00125909, then 1 tick -> 0x00125910.
- Arm alarm 0x00120005, one-shot; load 0x00120003; run 3 ticks -> alarm_o pulses once when time_o = 0x00120005, and alarm_armed_o falls in that cycle.
  - Repeat mode, alarm 0x00000000, start at 0x00235959 -> alarm_o and new_day_o coincide, and armed stays 1.
- time_update_i coincident with a prescaler wrap -> loaded value appears unchanged, the prescaler restarts at 0, and no pulses occur.
  - clock_en_i low for 10 cycles -> time_o and the prescaler are frozen.
- Assert rstn_i mid-count at 0x00101010 with the alarm armed -> time_o = 0, alarm_armed_o = 0, and no alarm_o or new_day_o after release.

Source files
------------

// File: rtl/rtc_clock.sv
// BCD hours:minutes:seconds counter driven by a prescaled 1 Hz tick, with a
// software-loadable alarm (one-shot or daily repeat) and a midnight pulse.
module rtc_clock #(
  parameter int unsigned PRESCALE = 32768,
  parameter int unsigned CNT_W    = 15
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clock_en_i,
  input  logic        time_update_i,
  input  logic [31:0] time_i,
  output logic [31:0] time_o,
  output logic        new_day_o,
  input  logic        alarm_update_i,
  input  logic [31:0] alarm_i,
  input  logic        alarm_mode_i,
  input  logic        alarm_clear_i,
  output logic        alarm_armed_o,
  output logic        alarm_o,
  output logic        tick_o
);

  typedef struct packed {
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } bcd_time_t;

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PRESCALE - 1);

  // Advance a two-digit BCD field whose units digit rolls over at 9.
  function automatic logic [6:0] inc_bcd7(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'h9) r = {v[6:4] + 3'd1, 4'h0};
    else                r = {v[6:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [5:0] inc_bcd6(input logic [5:0] v);
    logic [5:0] r;
    if (v[3:0] == 4'h9) r = {v[5:4] + 2'd1, 4'h0};
    else                r = {v[5:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [CNT_W-1:0] pre_q;
  bcd_time_t        time_q;
  bcd_time_t        time_inc;
  bcd_time_t        time_load;
  bcd_time_t        alarm_q;
  bcd_time_t        alarm_load;
  logic             mode_q;
  logic             armed_q;
  logic             tick_raw;
  logic             tick_eff;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hour_wrap;
  logic             day_wrap;
  logic             alarm_hit;
  logic             unused_bits;

  assign time_load  = '{hour: time_i[21:16],  min: time_i[14:8],  sec: time_i[6:0]};
  assign alarm_load = '{hour: alarm_i[21:16], min: alarm_i[14:8], sec: alarm_i[6:0]};
  assign unused_bits = ^{time_i[31:22], time_i[15], time_i[7],
                         alarm_i[31:22], alarm_i[15], alarm_i[7]};

  // A software load on the wrap cycle swallows the tick entirely.
  assign tick_raw = clock_en_i && (pre_q == PRE_MAX);
  assign tick_eff = tick_raw && !time_update_i;

  assign sec_wrap  = (time_q.sec  == 7'h59);
  assign min_wrap  = (time_q.min  == 7'h59);
  assign hour_wrap = (time_q.hour == 6'h23);
  assign day_wrap  = sec_wrap && min_wrap && hour_wrap;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    time_inc = time_q;
    if (sec_wrap) begin
      time_inc.sec = 7'h00;
      if (min_wrap) begin
        time_inc.min  = 7'h00;
        time_inc.hour = hour_wrap ? 6'h00 : inc_bcd6(time_q.hour);
      end else begin
        time_inc.min = inc_bcd7(time_q.min);
      end
    end else begin
      time_inc.sec = inc_bcd7(time_q.sec);
    end
  end

  assign alarm_hit = tick_eff && armed_q && (time_inc == alarm_q);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_q <= '0;
    end else if (time_update_i) begin
      pre_q <= '0;
    end else if (clock_en_i) begin
      pre_q <= tick_raw ? '0 : pre_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      time_q <= '0;
    end else if (time_update_i) begin
      time_q <= time_load;
    end else if (tick_eff) begin
      time_q <= time_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      alarm_q <= '0;
      mode_q  <= 1'b0;
    end else if (alarm_update_i) begin
      alarm_q <= alarm_load;
      mode_q  <= alarm_mode_i;
    end
  end

  // Clear beats a coincident update; a re-arm beats a one-shot disarm.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      armed_q <= 1'b0;
    end else if (alarm_clear_i) begin
      armed_q <= 1'b0;
    end else if (alarm_update_i) begin
      armed_q <= 1'b1;
    end else if (alarm_hit && !mode_q) begin
      armed_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tick_o    <= 1'b0;
      new_day_o <= 1'b0;
      alarm_o   <= 1'b0;
    end else begin
      tick_o    <= tick_eff;
      new_day_o <= tick_eff && day_wrap;
      alarm_o   <= alarm_hit;
    end
  end

  assign time_o        = {10'b0, time_q.hour, 1'b0, time_q.min, 1'b0, time_q.sec};
  assign alarm_armed_o = armed_q;

endmodule
